// File: rtl/scr1_tapc_fsm.sv
// JTAG TAP controller core: 1149.1 state machine, IR, bypass, TDO mux.
// Optional IDCODE register enabled by defining SCR1_TAPC_IDCODE_EN.
module scr1_tapc_fsm #(
  parameter int                         SCR1_IR_WIDTH   = 5,
  parameter int                         SCR1_DR_NUM     = 4,
  parameter logic [SCR1_IR_WIDTH-1:0]   SCR1_DR_OP_BASE = 'h10,
  parameter logic [SCR1_IR_WIDTH-1:0]   SCR1_IDCODE_OP  = 'h01,
  parameter logic [31:0]                SCR1_IDCODE_VAL = 32'h1000_0DB3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic                     tapc_rst_n_sync,
  output logic [SCR1_DR_NUM-1:0]   fsm_dr_select,
  output logic                     fsm_dr_capture,
  output logic                     fsm_dr_shift,
  output logic                     fsm_dr_update,
  output logic                     dr_din_serial,
  input  logic [SCR1_DR_NUM-1:0]   dr_dout_serial,
  output logic [SCR1_IR_WIDTH-1:0] ir_value
);

  typedef enum logic [3:0] {
    ST_TLR, ST_RTI,
    ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR,
    ST_PA_DR, ST_EX2_DR, ST_UPD_DR,
    ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR,
    ST_PA_IR, ST_EX2_IR, ST_UPD_IR
  } state_e;

`ifdef SCR1_TAPC_IDCODE_EN
  localparam logic [SCR1_IR_WIDTH-1:0] RST_OP = SCR1_IDCODE_OP;
`else
  localparam logic [SCR1_IR_WIDTH-1:0] RST_OP = '1;
`endif
  localparam logic [SCR1_IR_WIDTH-1:0] IR_CAP = SCR1_IR_WIDTH'(2'b01);

  state_e                     state_q, state_d;
  logic [SCR1_IR_WIDTH-1:0]   ir_sh_q;
  logic [SCR1_IR_WIDTH-1:0]   ir_q;
  logic                       bypass_q;
  logic                       tdo_q, tdo_en_q;
  logic [SCR1_DR_NUM-1:0]     dr_sel;
  logic                       idcode_sel, bypass_sel;
  logic                       idcode_bit;
  logic                       st_sh_ir, st_sh_dr;
  logic                       tdo_mux;

  assign st_sh_ir = (state_q == ST_SH_IR);
  assign st_sh_dr = (state_q == ST_SH_DR);

  // TAP state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_TLR;
    else     state_q <= state_d;
  end

  // 1149.1 next-state function of tms
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_TLR:    state_d = tms ? ST_TLR    : ST_RTI;
      ST_RTI:    state_d = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_d = tms ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_d = tms ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_d = tms ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_d = tms ? ST_UPD_DR : ST_PA_DR;
      ST_PA_DR:  state_d = tms ? ST_EX2_DR : ST_PA_DR;
      ST_EX2_DR: state_d = tms ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_d = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_d = tms ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_d = tms ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_d = tms ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_d = tms ? ST_UPD_IR : ST_PA_IR;
      ST_PA_IR:  state_d = tms ? ST_EX2_IR : ST_PA_IR;
      ST_EX2_IR: state_d = tms ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_d = tms ? ST_SEL_DR : ST_RTI;
    endcase
  end

  // IR shift register: capture fixed pattern, shift toward LSB
  always_ff @(posedge clk) begin
    if (rst)           ir_sh_q <= '0;
    else if (state_q == ST_CAP_IR)
                       ir_sh_q <= IR_CAP;
    else if (st_sh_ir) ir_sh_q <= {tdi, ir_sh_q[SCR1_IR_WIDTH-1:1]};
  end

  // IR shadow: updated on falling edge so decode settles before next rise
  always_ff @(negedge clk) begin
    if (rst)                         ir_q <= RST_OP;
    else if (state_q == ST_TLR)      ir_q <= RST_OP;
    else if (state_q == ST_UPD_IR)   ir_q <= ir_sh_q;
  end

  // Opcode decode to external DR select, IDCODE or BYPASS
  always_comb begin
    dr_sel     = '0;
    idcode_sel = 1'b0;
    for (int i = 0; i < SCR1_DR_NUM; i++) begin
      if (ir_q == SCR1_DR_OP_BASE + SCR1_IR_WIDTH'(i))
        dr_sel[i] = 1'b1;
    end
`ifdef SCR1_TAPC_IDCODE_EN
    if (ir_q == SCR1_IDCODE_OP) idcode_sel = 1'b1;
`endif
    bypass_sel = ~idcode_sel & ~(|dr_sel);
  end

  // Bypass register: single-bit pass-through when no real DR selected
  always_ff @(posedge clk) begin
    if (rst)                             bypass_q <= 1'b0;
    else if ((state_q == ST_CAP_DR) & bypass_sel)
                                         bypass_q <= 1'b0;
    else if (st_sh_dr & bypass_sel)      bypass_q <= tdi;
  end

`ifdef SCR1_TAPC_IDCODE_EN
  logic [31:0] idcode_sh_q;

  // IDCODE register: capture constant, shift toward LSB
  always_ff @(posedge clk) begin
    if (rst)                             idcode_sh_q <= '0;
    else if ((state_q == ST_CAP_DR) & idcode_sel)
                                         idcode_sh_q <= SCR1_IDCODE_VAL;
    else if (st_sh_dr & idcode_sel)      idcode_sh_q <= {tdi, idcode_sh_q[31:1]};
  end

  assign idcode_bit = idcode_sh_q[0];
`else
  assign idcode_bit = 1'b0;
`endif

  // Serial output select for the register currently shifting
  always_comb begin
    tdo_mux = 1'b0;
    if (st_sh_ir)                   tdo_mux = ir_sh_q[0];
    else if (st_sh_dr & idcode_sel) tdo_mux = idcode_bit;
    else if (st_sh_dr & bypass_sel) tdo_mux = bypass_q;
    else if (st_sh_dr)              tdo_mux = |(dr_sel & dr_dout_serial);
  end

  // TDO and its enable launch on falling edge; TDO holds outside shift
  always_ff @(negedge clk) begin
    if (rst) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_en_q <= st_sh_ir | st_sh_dr;
      if (st_sh_ir | st_sh_dr) tdo_q <= tdo_mux;
    end
  end

  assign tdo             = tdo_q;
  assign tdo_en          = tdo_en_q;
  assign tapc_rst_n_sync = (state_q != ST_TLR);
  assign fsm_dr_select   = dr_sel;
  assign fsm_dr_capture  = (state_q == ST_CAP_DR);
  assign fsm_dr_shift    = st_sh_dr;
  assign fsm_dr_update   = (state_q == ST_UPD_DR);
  assign dr_din_serial   = tdi;
  assign ir_value        = ir_q;

endmodule

// File: tb/tb_scr1_tapc_fsm.sv
// Directed bench for scr1_tapc_fsm: TAP walk, IR load, DR shifts, reset.
// Expectations follow SCR1_TAPC_IDCODE_EN when the bench is built with it.
module tb_scr1_tapc_fsm;

  logic       clk;
  logic       rst;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;
  logic       tapc_rst_n_sync;
  logic [3:0] fsm_dr_select;
  logic       fsm_dr_capture;
  logic       fsm_dr_shift;
  logic       fsm_dr_update;
  logic       dr_din_serial;
  logic [3:0] dr_dout_serial;
  logic [4:0] ir_value;

  int total = 0;
  int bad   = 0;

`ifdef SCR1_TAPC_IDCODE_EN
  localparam logic [4:0] RST_OP = 5'h01;
`else
  localparam logic [4:0] RST_OP = 5'h1F;
`endif

  scr1_tapc_fsm dut (
    .clk             (clk),
    .rst             (rst),
    .tms             (tms),
    .tdi             (tdi),
    .tdo             (tdo),
    .tdo_en          (tdo_en),
    .tapc_rst_n_sync (tapc_rst_n_sync),
    .fsm_dr_select   (fsm_dr_select),
    .fsm_dr_capture  (fsm_dr_capture),
    .fsm_dr_shift    (fsm_dr_shift),
    .fsm_dr_update   (fsm_dr_update),
    .dr_din_serial   (dr_din_serial),
    .dr_dout_serial  (dr_dout_serial),
    .ir_value        (ir_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // one TCK: drive, rise, fall; leaves time just after the falling edge
  task automatic tick(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    @(posedge clk);
    #2;
    @(negedge clk);
    #2;
  endtask

  // RTI -> shift n bits of din through DR -> RTI; dout[k] is tdo in k-th shift state
  task automatic shift_dr(input int n, input logic [31:0] din,
                          output logic [31:0] dout, output logic ok);
    dout = '0;
    ok   = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    ok &= fsm_dr_capture;
    tick(1'b0, 1'b0);
    dout[0] = tdo;
    ok &= tdo_en & fsm_dr_shift;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i]);
      if (i < n - 1) begin
        dout[i+1] = tdo;
        ok &= tdo_en;
      end
    end
    ok &= ~tdo_en & ~fsm_dr_shift;
    tick(1'b1, 1'b0);
    ok &= fsm_dr_update;
    tick(1'b0, 1'b0);
  endtask

  // RTI -> load IR with v (LSB first) -> RTI; seen holds tdo during shift
  task automatic shift_ir(input logic [4:0] v, output logic [4:0] seen);
    seen = '0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    seen[0] = tdo;
    for (int i = 0; i < 5; i++) begin
      tick(i == 4, v[i]);
      if (i < 4) seen[i+1] = tdo;
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  logic [31:0] d;
  logic [4:0]  s;
  logic        ok;

  initial begin
    rst = 1'b1;
    tms = 1'b1;
    tdi = 1'b0;
    dr_dout_serial = 4'b0000;

    tick(1'b1, 1'b0);
    chk("rst_tlr",   {31'b0, tapc_rst_n_sync}, 32'd0);
    chk("rst_ir",    {27'b0, ir_value}, {27'b0, RST_OP});
    chk("rst_tdoen", {31'b0, tdo_en}, 32'd0);
    chk("rst_tdo",   {31'b0, tdo}, 32'd0);
    rst = 1'b0;

    repeat (5) tick(1'b1, 1'b0);
    chk("tms5_tlr", {31'b0, tapc_rst_n_sync}, 32'd0);
    chk("tms5_ir",  {27'b0, ir_value}, {27'b0, RST_OP});
    chk("tms5_en",  {31'b0, tdo_en}, 32'd0);

    tick(1'b0, 1'b0);
    chk("rti", {31'b0, tapc_rst_n_sync}, 32'd1);

`ifdef SCR1_TAPC_IDCODE_EN
    shift_dr(32, 32'h0, d, ok);
    chk("idcode_stream", d, 32'h1000_0DB3);
`else
    shift_dr(8, 32'hA5, d, ok);
    chk("rstop_bypass", {24'b0, d[7:0]}, 32'h4A);
`endif
    chk("rstop_ctl", {31'b0, ok}, 32'd1);

    shift_ir(5'h12, s);
    chk("ir12_cap", {27'b0, s}, 32'h01);
    chk("ir12_val", {27'b0, ir_value}, 32'h12);
    chk("ir12_sel", {28'b0, fsm_dr_select}, 32'b0100);

    dr_dout_serial = 4'b0100;
    shift_dr(4, 32'h0, d, ok);
    chk("dr2_ones", {28'b0, d[3:0]}, 32'hF);
    chk("dr2_ctl",  {31'b0, ok}, 32'd1);
    dr_dout_serial = 4'b1011;
    shift_dr(4, 32'hF, d, ok);
    chk("dr2_zero", {28'b0, d[3:0]}, 32'h0);

    shift_ir(5'h10, s);
    chk("ir10_sel", {28'b0, fsm_dr_select}, 32'b0001);
    shift_ir(5'h13, s);
    chk("ir13_sel", {28'b0, fsm_dr_select}, 32'b1000);

    dr_dout_serial = 4'hF;
    shift_ir(5'h1F, s);
    chk("ir1f_val", {27'b0, ir_value}, 32'h1F);
    chk("ir1f_sel", {28'b0, fsm_dr_select}, 32'd0);
    shift_dr(8, 32'hA5, d, ok);
    chk("bypass_a5", {24'b0, d[7:0]}, 32'h4A);
    chk("bypass_ctl", {31'b0, ok}, 32'd1);

    shift_ir(5'h07, s);
    chk("ir07_sel", {28'b0, fsm_dr_select}, 32'd0);
    shift_dr(8, 32'h3C, d, ok);
    chk("unk_bypass", {24'b0, d[7:0]}, 32'h78);

    shift_ir(5'h01, s);
    chk("ir01_sel", {28'b0, fsm_dr_select}, 32'd0);
`ifdef SCR1_TAPC_IDCODE_EN
    shift_dr(32, 32'h0, d, ok);
    chk("ir01_idcode", d, 32'h1000_0DB3);
`else
    shift_dr(8, 32'hA5, d, ok);
    chk("ir01_bypass", {24'b0, d[7:0]}, 32'h4A);
`endif

    shift_ir(5'h12, s);
    dr_dout_serial = 4'b0100;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("mid_shift", {31'b0, fsm_dr_shift}, 32'd1);
    chk("mid_en",    {31'b0, tdo_en}, 32'd1);
    rst = 1'b1;
    tms = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_mid_tlr",   {31'b0, tapc_rst_n_sync}, 32'd0);
    chk("rst_mid_shift", {31'b0, fsm_dr_shift}, 32'd0);
    chk("rst_mid_irkeep", {27'b0, ir_value}, 32'h12);
    @(negedge clk);
    #2;
    chk("rst_mid_en", {31'b0, tdo_en}, 32'd0);
    chk("rst_mid_ir", {27'b0, ir_value}, {27'b0, RST_OP});
    rst = 1'b0;

    tick(1'b0, 1'b0);
    shift_ir(5'h11, s);
    chk("ir11_sel", {28'b0, fsm_dr_select}, 32'b0010);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("shir_en", {31'b0, tdo_en}, 32'd1);
    repeat (5) tick(1'b1, 1'b0);
    chk("shir_tms5_tlr", {31'b0, tapc_rst_n_sync}, 32'd0);
    chk("shir_tms5_ir",  {27'b0, ir_value}, {27'b0, RST_OP});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
